// File: rtl/spi_sibal_master_core.sv
// SPI master shift engine: one full-duplex MSB-first frame per accepted start; optional SPI_SIBAL_LOOPBACK_EN routes mosi to the sampler.
// Latency start->done (2*DATA_W+2)*(clk_div+1)+1 cycles; start is ignored while busy or in the done cycle, nothing is queued.
module spi_sibal_master_core #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  clk_div,
`ifdef SPI_SIBAL_LOOPBACK_EN
    input  logic              loopback,
`endif
    input  logic              miso,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n
);

    localparam int EW = $clog2(2 * DATA_W);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ASSERT = 3'd1,
        S_SHIFT  = 3'd2,
        S_HOLD   = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  hp_q, hp_d, div_q, div_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
    logic              sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              hp_exp, last_edge, leading, sample_bit;
`ifdef SPI_SIBAL_LOOPBACK_EN
    logic              lb_q, lb_d;
    assign sample_bit = lb_q ? mosi_q : miso;
`else
    assign sample_bit = miso;
`endif

    assign hp_exp    = (hp_q == div_q);
    assign last_edge = (edge_q == LAST_EDGE);
    assign leading   = ~edge_q[0];

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= S_IDLE;
            hp_q      <= '0;
            div_q     <= '0;
            edge_q    <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SPI_SIBAL_LOOPBACK_EN
            lb_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            hp_q      <= hp_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SPI_SIBAL_LOOPBACK_EN
            lb_q      <= lb_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_ASSERT;
            S_ASSERT: if (hp_exp) state_d = S_SHIFT;
            S_SHIFT:  if (hp_exp && last_edge) state_d = S_HOLD;
            S_HOLD:   if (hp_exp) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hp_d    = hp_q;
        div_d   = div_q;
        edge_d  = edge_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        tx_sr_d = tx_sr_q;
        rx_sr_d = rx_sr_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
`ifdef SPI_SIBAL_LOOPBACK_EN
        lb_d    = lb_q;
`endif
        case (state_q)
            S_IDLE: begin
                sclk_d = cpol;
                hp_d   = '0;
                edge_d = '0;
                if (start) begin
                    div_d   = clk_div;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    rx_sr_d = '0;
`ifdef SPI_SIBAL_LOOPBACK_EN
                    lb_d    = loopback;
`endif
                    // CPHA=1 holds mosi low and emits the MSB on the first leading edge
                    if (cpha) begin
                        mosi_d  = 1'b0;
                        tx_sr_d = tx_data;
                    end else begin
                        mosi_d  = tx_data[DATA_W-1];
                        tx_sr_d = tx_data << 1;
                    end
                end
            end
            S_ASSERT, S_HOLD: begin
                hp_d = hp_exp ? '0 : hp_q + 1'b1;
            end
            S_SHIFT: begin
                hp_d = hp_exp ? '0 : hp_q + 1'b1;
                if (hp_exp) begin
                    sclk_d = ~sclk_q;
                    edge_d = last_edge ? '0 : edge_q + 1'b1;
                    if (leading != cpha_q)
                        rx_sr_d = {rx_sr_q[DATA_W-2:0], sample_bit};
                    if (cpha_q ? leading : (!leading && !last_edge)) begin
                        mosi_d  = tx_sr_q[DATA_W-1];
                        tx_sr_d = tx_sr_q << 1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        cs_n_d    = !(state_d == S_ASSERT || state_d == S_SHIFT || state_d == S_HOLD);
        busy_d    = !cs_n_d;
        done_d    = (state_d == S_DONE);
        rx_data_d = done_d ? rx_sr_q : rx_data_q;
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;

endmodule
